// File: rtl/ram_rw_ctrl.sv
// ram_rw_ctrl
//   Access sequencer in front of a small R/W RAM. Takes single WRITE/READ
//   commands and whole-memory FILL/DUMP commands over a valid/ready command
//   channel, drives the RAM's sel/addr/din pins and returns read data over a
//   valid/ready response channel. The RAM shares clk/reset with this block.
//
// Ports
//   clk, reset            clock (posedge) / synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready only in IDLE
//   cmd_op                00=WRITE 01=READ 10=FILL 11=DUMP
//   cmd_addr, cmd_data    address (WRITE/READ), data (WRITE) or seed (FILL)
//   rsp_valid/rsp_ready   response handshake
//   rsp_addr, rsp_data    address and data of the response
//   busy                  high whenever the sequencer is not IDLE
//   ram_sel               to RAM: 1=write, 0=read
//   ram_addr, ram_din     to RAM
//   ram_dout              from RAM, registered (valid 1 cycle after a read)
module ram_rw_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  ram_sel,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_FILL,
    S_RD_ISS,
    S_RD_CAP,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_FILL  = 2'b10,
    OP_DUMP  = 2'b11
  } op_e;

  state_e                  state, state_nxt;
  op_e                     op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    cnt_last;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  assign cnt_last = (cnt == LAST_ADDR);
  // DUMP walks the counter; READ uses the captured address
  assign rd_addr  = (op_q == OP_DUMP) ? cnt : addr_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    ram_sel   = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_WRITE: state_nxt = S_WR;
            OP_FILL:  state_nxt = S_FILL;
            default:  state_nxt = S_RD_ISS;
          endcase
        end
      end
      S_WR: begin
        ram_sel   = 1'b1;
        ram_addr  = addr_q;
        ram_din   = data_q;
        state_nxt = S_IDLE;
      end
      S_FILL: begin
        ram_sel  = 1'b1;
        ram_addr = cnt;
        ram_din  = data_q + DATA_WIDTH'(cnt);
        if (cnt_last) state_nxt = S_IDLE;
      end
      S_RD_ISS: begin
        ram_addr  = rd_addr;
        state_nxt = S_RD_CAP;
      end
      S_RD_CAP: begin
        ram_addr  = rd_addr;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        ram_addr  = rd_addr;
        if (rsp_ready) begin
          if (op_q == OP_DUMP && !cnt_last) state_nxt = S_RD_ISS;
          else                              state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Reset must stop a write in the very cycle it is asserted, before the
    // state register has had an edge to return to IDLE.
    if (reset) begin
      ram_sel   = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
      rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_WRITE;
      addr_q   <= '0;
      data_q   <= '0;
      cnt      <= '0;
      rsp_addr <= '0;
      rsp_data <= '0;
    end else begin
      if (state == S_IDLE && cmd_valid) begin
        op_q   <= op_e'(cmd_op);
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        cnt    <= '0;
      end
      if (state == S_FILL && !cnt_last)
        cnt <= cnt + ADDR_WIDTH'(1);
      if (state == S_RD_CAP) begin
        rsp_data <= ram_dout;
        rsp_addr <= rd_addr;
      end
      if (state == S_RESP && rsp_ready && op_q == OP_DUMP && !cnt_last)
        cnt <= cnt + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ram_rw_ctrl.sv
// tb_ram_rw_ctrl
//   Directed bench for ram_rw_ctrl with a behavioural 4x4 RAM attached
//   (synchronous reset clears contents, registered read port).
module tb_ram_rw_ctrl;

  localparam int AW = 2;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          ram_sel;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int sel_cnt = 0;

  ram_rw_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .busy(busy),
    .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model
  logic [DW-1:0] mem [4];
  always @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
      ram_dout <= '0;
    end else if (ram_sel) begin
      mem[ram_addr] <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  always @(negedge clk) if (ram_sel === 1'b1) sel_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Leaves the bench in cycle T+1 (first cycle after acceptance).
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int w;
    w = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && w < 20) begin tick; w++; end
    check("send_ready", {31'd0, cmd_ready}, 32'd1);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick; lat++; end
    check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat;
    send(2'b01, a, '0);
    wait_rsp(lat);
    check({tag, "_lat"}, lat, 3);
    check({tag, "_addr"}, {30'd0, rsp_addr}, {30'd0, a});
    check({tag, "_data"}, {28'd0, rsp_data}, {28'd0, d});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] fill_exp [4];
    int s0, t1, got, last_c, lat, seen;
    fill_exp = '{4'hE, 4'hF, 4'h0, 4'h1};

    tick; tick;
    reset = 1'b0;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_addr", {30'd0, rsp_addr}, 32'd0);
    check("rst_rsp_data", {28'd0, rsp_data}, 32'd0);
    check("rst_ram_sel", {31'd0, ram_sel}, 32'd0);
    check("rst_ram_addr", {30'd0, ram_addr}, 32'd0);
    check("rst_ram_din", {28'd0, ram_din}, 32'd0);

    // 1: write then read back
    s0 = sel_cnt;
    send(2'b00, 2'd2, 4'h9);
    check("wr_sel", {31'd0, ram_sel}, 32'd1);
    check("wr_addr", {30'd0, ram_addr}, 32'd2);
    check("wr_din", {28'd0, ram_din}, 32'h9);
    tick; tick;
    check("wr_sel_cycles", sel_cnt - s0, 1);
    do_read("rd2", 2'd2, 4'h9);

    // 2: fill with wrapping seed, then dump
    s0 = sel_cnt;
    send(2'b10, 2'd0, 4'hE);
    for (int i = 0; i < 4; i++) begin
      check("fill_sel", {31'd0, ram_sel}, 32'd1);
      check("fill_addr", {30'd0, ram_addr}, i);
      check("fill_din", {28'd0, ram_din}, {28'd0, fill_exp[i]});
      tick;
    end
    check("fill_done_busy", {31'd0, busy}, 32'd0);
    check("fill_sel_cycles", sel_cnt - s0, 4);
    send(2'b11, 2'd3, 4'h0);
    t1 = cyc; got = 0; last_c = 0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && got < 4; k++) begin
      if (rsp_valid) begin
        check("dump_addr", {30'd0, rsp_addr}, got);
        check("dump_data", {28'd0, rsp_data}, {28'd0, fill_exp[got]});
        if (got == 0) check("dump_first_lat", cyc - t1, 2);
        else          check("dump_gap", cyc - last_c, 3);
        last_c = cyc;
        got++;
      end
      tick;
    end
    rsp_ready = 1'b0;
    check("dump_count", got, 4);
    check("dump_end_valid", {31'd0, rsp_valid}, 32'd0);
    check("dump_end_busy", {31'd0, busy}, 32'd0);

    // 3: response back-pressure; command during stall ignored
    s0 = sel_cnt;
    send(2'b01, 2'd1, 4'h0);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_addr", {30'd0, rsp_addr}, 32'd1);
      check("stall_data", {28'd0, rsp_data}, 32'hF);
      check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      if (i == 1) begin cmd_op = 2'b00; cmd_addr = 2'd1; cmd_data = 4'h3; cmd_valid = 1'b1; end
      if (i == 2) begin cmd_valid = 1'b0; cmd_addr = 2'd2; end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("stall_drop", {31'd0, rsp_valid}, 32'd0);
    check("stall_busy", {31'd0, busy}, 32'd0);
    check("stall_no_write", sel_cnt - s0, 0);
    do_read("rd1_after_stall", 2'd1, 4'hF);

    // 4: reset during fill
    s0 = sel_cnt;
    send(2'b10, 2'd0, 4'h7);
    tick;
    check("fill1_sel", {31'd0, ram_sel}, 32'd1);
    check("fill1_addr", {30'd0, ram_addr}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstcyc_sel", {31'd0, ram_sel}, 32'd0);
    tick;
    reset = 1'b0;
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("postrst_sel", {31'd0, ram_sel}, 32'd0);
    tick; tick;
    check("rstfill_sel_cycles", sel_cnt - s0, 1);
    do_read("rd3_cleared", 2'd3, 4'h0);
    do_read("rd0_cleared", 2'd0, 4'h0);

    // 5: reset while a response is pending
    send(2'b00, 2'd3, 4'hA);
    tick;
    send(2'b01, 2'd3, 4'h0);
    wait_rsp(lat);
    check("rsp5_data", {28'd0, rsp_data}, 32'hA);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rsp5_dropped", {31'd0, rsp_valid}, 32'd0);
    check("rsp5_busy", {31'd0, busy}, 32'd0);
    rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) seen++;
      tick;
    end
    rsp_ready = 1'b0;
    check("rsp5_none_after", seen, 0);

    // 6: back-to-back writes, second held valid through the first's WR cycle
    s0 = sel_cnt;
    send(2'b00, 2'd2, 4'hC);
    cmd_op = 2'b00; cmd_addr = 2'd0; cmd_data = 4'h5; cmd_valid = 1'b1;
    check("b2b_wr_ready", {31'd0, cmd_ready}, 32'd0);
    tick;
    check("b2b_idle_ready", {31'd0, cmd_ready}, 32'd1);
    tick;
    cmd_valid = 1'b0;
    check("b2b_addr", {30'd0, ram_addr}, 32'd0);
    check("b2b_din", {28'd0, ram_din}, 32'h5);
    tick; tick;
    check("b2b_sel_cycles", sel_cnt - s0, 2);
    do_read("rd0_b2b", 2'd0, 4'h5);
    do_read("rd2_b2b", 2'd2, 4'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
